// File: rtl/conv3x3_mac_pipe.sv
// conv3x3_mac_pipe: three-stage pipelined 3x3 signed convolution MAC.
//   S1 registers the nine pixel*coef products, S2 their sum, S3 the shifted,
//   optionally ReLU-clamped and saturated result.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         input beat handshake (in_ready is combinational)
//   in1, in2, in3               pixel rows 0..2, col0 in the low slice
//   coef_we/coef_addr/coef_data runtime kernel write (index row*3+col, 0..8)
//   relu_en                     per-beat ReLU enable, captured with the beat
//   out_valid / out_ready       result handshake
//   out, out_sat                signed result and saturation flag
module conv3x3_mac_pipe #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned OUT_W  = 13,
  parameter int unsigned SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*DATA_W-1:0]   in1,
  input  logic [3*DATA_W-1:0]   in2,
  input  logic [3*DATA_W-1:0]   in3,
  input  logic                  coef_we,
  input  logic [3:0]            coef_addr,
  input  logic [COEF_W-1:0]     coef_data,
  input  logic                  relu_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out,
  output logic                  out_sat
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = DATA_W + COEF_W + 4;
  localparam int unsigned NTAP   = 9;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Reset value of the kernel, index = row*3+col
  function automatic logic signed [COEF_W-1:0] dflt_coef(input int idx);
    case (idx)
      0:       return COEF_W'(2);
      1:       return COEF_W'(-2);
      2:       return COEF_W'(-1);
      3:       return COEF_W'(-1);
      4:       return COEF_W'(2);
      5:       return COEF_W'(1);
      6:       return COEF_W'(4);
      7:       return COEF_W'(5);
      default: return COEF_W'(1);
    endcase
  endfunction

  logic                     en;
  logic signed [COEF_W-1:0] coef   [NTAP];
  logic signed [DATA_W-1:0] pix_c  [NTAP];
  logic signed [PROD_W-1:0] prod_c [NTAP];
  logic signed [PROD_W-1:0] p1     [NTAP];
  logic                     v1, r1;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  sum2;
  logic                     v2, r2;
  logic signed [ACC_W-1:0]  shifted_c;
  logic signed [ACC_W-1:0]  clamp_c;
  logic [OUT_W-1:0]         res_c;
  logic                     sat_c;

  // Whole pipeline advances together; a held output blocks everything behind it
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Unpack pixels and form the nine products against the current kernel
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pix_c[i]   = in1[i*DATA_W +: DATA_W];
      pix_c[3+i] = in2[i*DATA_W +: DATA_W];
      pix_c[6+i] = in3[i*DATA_W +: DATA_W];
    end
    for (int i = 0; i < int'(NTAP); i++) begin
      prod_c[i] = PROD_W'(pix_c[i]) * PROD_W'(coef[i]);
    end
  end

  // Adder tree; ACC_W leaves headroom for nine full-scale products
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(NTAP); i++) begin
      sum_c = sum_c + ACC_W'(p1[i]);
    end
  end

  // Shift, ReLU, then saturate; ReLU zeroing is not a clip
  always_comb begin
    shifted_c = sum2 >>> SHIFT;
    clamp_c   = shifted_c;
    sat_c     = 1'b0;
    if (r2 && shifted_c[ACC_W-1]) begin
      clamp_c = '0;
    end else if (shifted_c > SAT_MAX) begin
      clamp_c = SAT_MAX;
      sat_c   = 1'b1;
    end else if (shifted_c < SAT_MIN) begin
      clamp_c = SAT_MIN;
      sat_c   = 1'b1;
    end
    res_c = OUT_W'(clamp_c);
  end

  // Control path, kernel storage and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      out_sat   <= 1'b0;
      for (int i = 0; i < int'(NTAP); i++) begin
        coef[i] <= dflt_coef(i);
      end
    end else begin
      // Kernel writes land at the edge, so a beat accepted this edge sees the old kernel
      if (coef_we && (coef_addr <= 4'd8)) begin
        coef[coef_addr] <= coef_data;
      end
      if (en) begin
        v1        <= in_valid;
        v2        <= v1;
        out_valid <= v2;
        if (v2) begin
          out     <= res_c;
          out_sat <= sat_c;
        end
      end
    end
  end

  // Datapath registers; contents only matter when the matching valid is set
  always_ff @(posedge clk) begin
    if (en) begin
      p1   <= prod_c;
      r1   <= relu_en;
      sum2 <= sum_c;
      r2   <= r1;
    end
  end

endmodule

// File: tb/tb_conv3x3_mac_pipe.sv
// tb_conv3x3_mac_pipe: directed bench for conv3x3_mac_pipe at default parameters.
module tb_conv3x3_mac_pipe;

  typedef logic signed [12:0] res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [38:0] in1, in2, in3;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_data;
  logic        relu_en;
  logic        out_valid;
  logic        out_ready;
  res_t        out;
  logic        out_sat;

  int   n_chk  = 0;
  int   n_fail = 0;
  res_t rx_q[$];
  logic rxs_q[$];

  conv3x3_mac_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .in3(in3),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  // Record every result handed over downstream
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      rx_q.push_back(out);
      rxs_q.push_back(out_sat);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [38:0] all3(input res_t v);
    return {v, v, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait for acceptance, then scramble the don't-care inputs
  task automatic send(input logic [38:0] r0, input logic [38:0] r1, input logic [38:0] r2,
                      input logic relu);
    int c = 0;
    in1 = r0; in2 = r1; in3 = r2; relu_en = relu; in_valid = 1'b1;
    #1;
    while (!in_ready && c < 50) begin
      @(posedge clk); #2; c++;
    end
    if (c >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL send_accept: in_ready stayed %0b, required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    relu_en  = ~relu;
    in1 = {$urandom, $urandom};
    in2 = {$urandom, $urandom};
    in3 = {$urandom, $urandom};
  endtask

  task automatic wait_rx(input int n);
    int c = 0;
    while (rx_q.size() < n && c < 60) begin
      tick(); c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    relu_en = 1'b0; out_ready = 1'b1; in1 = '0; in2 = '0; in3 = '0;
    tick(); tick();
    rst = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || out !== 13'sd0 || out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b out=%0d sat=%0b, required 0/0/0", out_valid, out, out_sat);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int c;
    rx_q.delete(); rxs_q.delete();
    out_ready = 1'b1;
    in1 = all3(1); in2 = all3(1); in3 = all3(1); relu_en = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early: out_valid=%0b two edges after accept, required 0", out_valid);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out !== 13'sd11 || out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency: valid=%0b out=%0d sat=%0b, required 1/11/0", out_valid, out, out_sat);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_single: out_valid=%0b a cycle later, required 0", out_valid);
    end
    // Distinct pixel per tap: tap i carries i+1 -> sum coef[i]*(i+1) = 84
    rx_q.delete(); rxs_q.delete();
    send({13'sd3, 13'sd2, 13'sd1}, {13'sd6, 13'sd5, 13'sd4}, {13'sd9, 13'sd8, 13'sd7}, 1'b0);
    wait_rx(1);
    n_chk++;
    c = rx_q.size();
    if (c < 1 || rx_q[0] !== 13'sd84) begin
      n_fail++;
      $display("FAIL basic_taps: got %0d results first=%0d, required 84", c, (c > 0) ? rx_q[0] : 13'sd0);
    end
  endtask

  task automatic test_relu();
    res_t exp_v [3] = '{-13'sd11, 13'sd0, 13'sd11};
    rx_q.delete(); rxs_q.delete();
    out_ready = 1'b1;
    send(all3(-1), all3(-1), all3(-1), 1'b0);
    send(all3(-1), all3(-1), all3(-1), 1'b1);
    send(all3(1),  all3(1),  all3(1),  1'b1);
    wait_rx(3);
    n_chk++;
    if (rx_q.size() != 3) begin
      n_fail++;
      $display("FAIL relu_count: got %0d results, required 3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (rx_q[i] !== exp_v[i] || rxs_q[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL relu_beat%0d: out=%0d sat=%0b, required %0d/0", i, rx_q[i], rxs_q[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   k = 1;
    int   c = 0;
    bit   saw_stall = 0;
    bit   acc, hold;
    res_t prev;
    rx_q.delete(); rxs_q.delete();
    while (k <= 6 && c < 100) begin
      out_ready = !(c >= 3 && c < 8);
      in1 = all3(13'(k)); in2 = all3(13'(k)); in3 = all3(13'(k));
      relu_en = 1'b0; in_valid = 1'b1;
      #1;
      if (!in_ready) saw_stall = 1;
      acc  = in_ready;
      hold = out_valid && !out_ready;
      prev = out;
      tick();
      if (hold) begin
        n_chk++;
        if (out_valid !== 1'b1 || out !== prev) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%0b out=%0d, required 1/%0d", out_valid, out, prev);
        end
      end
      if (acc) k++;
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_rx(6);
    repeat (4) tick();
    n_chk++;
    if (!saw_stall) begin
      n_fail++;
      $display("FAIL stall_in_ready: in_ready never dropped, required a drop");
    end
    n_chk++;
    if (rx_q.size() != 6) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results, required 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_chk++;
        if (rx_q[i] !== 13'(11 * (i + 1))) begin
          n_fail++;
          $display("FAIL stream_beat%0d: got %0d required %0d", i, rx_q[i], 11 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_coef_write();
    rx_q.delete(); rxs_q.delete();
    out_ready = 1'b1;
    coef_we = 1'b1; coef_addr = 4'd4; coef_data = 8'sd10;
    send(all3(1), all3(1), all3(1), 1'b0);
    coef_we = 1'b0;
    send(all3(1), all3(1), all3(1), 1'b0);
    coef_we = 1'b1; coef_addr = 4'd12; coef_data = 8'sd50;
    tick();
    coef_we = 1'b0;
    send(all3(1), all3(1), all3(1), 1'b0);
    wait_rx(3);
    n_chk++;
    if (rx_q.size() != 3) begin
      n_fail++;
      $display("FAIL coef_count: got %0d results, required 3", rx_q.size());
    end else begin
      n_chk++;
      if (rx_q[0] !== 13'sd11) begin
        n_fail++;
        $display("FAIL coef_old_kernel: got %0d required 11", rx_q[0]);
      end
      n_chk++;
      if (rx_q[1] !== 13'sd19) begin
        n_fail++;
        $display("FAIL coef_new_kernel: got %0d required 19", rx_q[1]);
      end
      n_chk++;
      if (rx_q[2] !== 13'sd19) begin
        n_fail++;
        $display("FAIL coef_bad_addr: got %0d required 19", rx_q[2]);
      end
    end
  endtask

  task automatic test_saturation();
    rx_q.delete(); rxs_q.delete();
    out_ready = 1'b1;
    send(all3(4095), all3(4095), all3(4095), 1'b0);
    for (int a = 0; a < 9; a++) begin
      coef_we = 1'b1; coef_addr = 4'(a); coef_data = 8'h80;
      tick();
    end
    coef_we = 1'b0;
    send(all3(4095), all3(4095), all3(4095), 1'b0);
    wait_rx(2);
    n_chk++;
    if (rx_q.size() != 2) begin
      n_fail++;
      $display("FAIL sat_count: got %0d results, required 2", rx_q.size());
    end else begin
      n_chk++;
      if (rx_q[0] !== 13'sd4095 || rxs_q[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_pos: out=%0d sat=%0b, required 4095/1", rx_q[0], rxs_q[0]);
      end
      n_chk++;
      if (rx_q[1] !== -13'sd4096 || rxs_q[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_neg: out=%0d sat=%0b, required -4096/1", rx_q[1], rxs_q[1]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    rx_q.delete(); rxs_q.delete();
    out_ready = 1'b1;
    send(all3(3), all3(3), all3(3), 1'b0);
    send(all3(5), all3(5), all3(5), 1'b0);
    in1 = all3(7); in2 = all3(7); in3 = all3(7); in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_state: valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready);
    end
    repeat (8) tick();
    n_chk++;
    if (rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_flush: got %0d stale results, required 0", rx_q.size());
    end
    rx_q.delete(); rxs_q.delete();
    send(all3(1), all3(1), all3(1), 1'b0);
    wait_rx(1);
    n_chk++;
    if (rx_q.size() != 1 || rx_q[0] !== 13'sd11) begin
      n_fail++;
      $display("FAIL midreset_kernel: got %0d results first=%0d, required 11",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 13'sd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic();
    test_relu();
    test_back_to_back();
    test_coef_write();
    test_saturation();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
